// File: rtl/md_unit_if.sv
// Handshake/data bundle between the E stage and the multiply/divide unit.
//   start : E-stage MD op valid this cycle (one-cycle pulse)
//   op    : 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   a, b  : rs / rt operands (forwarded)
//   busy  : arithmetic op in flight
//   hi/lo : architectural HI/LO registers
interface md_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  // Pipeline side drives operands and samples status/results.
  modport master (output start, op, a, b, input busy, hi, lo);
  // Unit side.
  modport slave (input start, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding the HI/LO register pair.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   md  : md_unit_if.slave (start/op/a/b in, busy/hi/lo out, all outputs registered)
// An accepted MULT/MULTU/DIV/DIVU holds busy high for exactly MUL_CYCLES or
// DIV_CYCLES cycles; HI/LO update on the edge where busy falls. MTHI/MTLO write
// in one cycle without raising busy. Starts while busy are dropped.
module md_unit #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input logic      clk,
  input logic      rst,
  md_unit_if.slave md
);

  localparam int unsigned MaxCycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  typedef enum logic {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;
  logic              busy_q, busy_d;

  // Arithmetic on the latched operands. Signed ops go through magnitudes so
  // the 0x80000000 / -1 case wraps naturally and no signed divide is needed.
  logic        is_signed, is_div;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [63:0] prod_mag, prod;
  logic [31:0] quo_mag, rem_mag, quo, rem;

  always_comb begin
    is_signed = ~op_q[0];
    is_div    = op_q[1];
    a_neg     = is_signed & a_q[31];
    b_neg     = is_signed & b_q[31];
    a_mag     = a_neg ? (32'd0 - a_q) : a_q;
    b_mag     = b_neg ? (32'd0 - b_q) : b_q;
    prod_mag  = {32'd0, a_mag} * {32'd0, b_mag};
    prod      = (a_neg ^ b_neg) ? (64'd0 - prod_mag) : prod_mag;
    // Guarded so a zero divisor never feeds the divider; result unused then.
    if (b_mag == 32'd0) begin
      quo_mag = 32'd0;
      rem_mag = 32'd0;
    end else begin
      quo_mag = a_mag / b_mag;
      rem_mag = a_mag % b_mag;
    end
    quo = (a_neg ^ b_neg) ? (32'd0 - quo_mag) : quo_mag;
    // Remainder follows the sign of the dividend.
    rem = a_neg ? (32'd0 - rem_mag) : rem_mag;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    unique case (state_q)
      StIdle: begin
        if (md.start) begin
          if (!md.op[2]) begin
            state_d = StRun;
            op_d    = md.op[1:0];
            a_d     = md.a;
            b_d     = md.b;
            cnt_d   = md.op[1] ? CntW'(DIV_CYCLES) : CntW'(MUL_CYCLES);
            busy_d  = 1'b1;
          end else if (md.op == 3'd4) begin
            hi_d = md.a;
          end else if (md.op == 3'd5) begin
            lo_d = md.a;
          end
        end
      end
      StRun: begin
        // Incoming starts are ignored here; the op in flight always completes.
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          if (is_div) begin
            if (b_q != 32'd0) begin
              hi_d = rem;
              lo_d = quo;
            end
          end else begin
            hi_d = prod[63:32];
            lo_d = prod[31:0];
          end
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign md.busy = busy_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  md_unit_if md_if ();

  md_unit #(
    .MUL_CYCLES(5),
    .DIV_CYCLES(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .md (md_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one start pulse for one edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    md_if.start = 1'b1;
    md_if.op    = op;
    md_if.a     = a;
    md_if.b     = b;
    step();
    md_if.start = 1'b0;
    md_if.op    = 3'd7;
  endtask

  // Count cycles busy stays high, bounded at 50.
  task automatic wait_idle(output int n);
    n = 0;
    while (md_if.busy && n < 50) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    #3;
    total++;
    if (md_if.busy !== 1'b0 || md_if.hi !== 32'd0 || md_if.lo !== 32'd0) begin
      bad++;
      $display("FAIL reset_state: busy=%b hi=%h lo=%h want 0/0/0", md_if.busy, md_if.hi, md_if.lo);
    end
    step();
    rst = 1'b0;
    // Preload so the mid-op reset clearing is observable.
    issue(3'd4, 32'hAAAA_0001, 32'd0);
    issue(3'd5, 32'hBBBB_0002, 32'd0);
    issue(3'd2, 32'd100, 32'd7);
    step(); step(); step();
    #2 rst = 1'b1;
    #1;
    total++;
    if (md_if.busy !== 1'b0 || md_if.hi !== 32'd0 || md_if.lo !== 32'd0) begin
      bad++;
      $display("FAIL reset_mid_div: busy=%b hi=%h lo=%h want 0/0/0", md_if.busy, md_if.hi, md_if.lo);
    end
    #2 rst = 1'b0;
    n = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (md_if.busy !== 1'b0 || md_if.hi !== 32'd0 || md_if.lo !== 32'd0) n++;
    end
    total++;
    if (n != 0) begin
      bad++;
      $display("FAIL reset_no_commit: %0d bad cycles, hi=%h lo=%h want none", n, md_if.hi, md_if.lo);
    end
  endtask

  task automatic test_mult();
    int n;
    issue(3'd0, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    total++;
    if (n != 5) begin
      bad++;
      $display("FAIL mult_busy: got %0d cycles want 5", n);
    end
    total++;
    if (md_if.hi !== 32'hFFFF_FFFF || md_if.lo !== 32'hFFFF_FFFA) begin
      bad++;
      $display("FAIL mult_result: hi=%h lo=%h want ffffffff/fffffffa", md_if.hi, md_if.lo);
    end
    issue(3'd1, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    total++;
    if (n != 5 || md_if.hi !== 32'h0000_0002 || md_if.lo !== 32'hFFFF_FFFA) begin
      bad++;
      $display("FAIL multu: n=%0d hi=%h lo=%h want 5 00000002/fffffffa", n, md_if.hi, md_if.lo);
    end
  endtask

  task automatic test_div();
    int n;
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    total++;
    if (n != 10) begin
      bad++;
      $display("FAIL div_busy: got %0d cycles want 10", n);
    end
    total++;
    if (md_if.hi !== 32'hFFFF_FFFF || md_if.lo !== 32'hFFFF_FFFD) begin
      bad++;
      $display("FAIL div_signed: hi=%h lo=%h want ffffffff/fffffffd", md_if.hi, md_if.lo);
    end
    issue(3'd3, 32'd7, 32'd2);
    wait_idle(n);
    total++;
    if (n != 10 || md_if.hi !== 32'd1 || md_if.lo !== 32'd3) begin
      bad++;
      $display("FAIL divu: n=%0d hi=%h lo=%h want 10 1/3", n, md_if.hi, md_if.lo);
    end
  endtask

  task automatic test_div_edges();
    int n;
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    total++;
    if (n != 10 || md_if.hi !== 32'd0 || md_if.lo !== 32'h8000_0000) begin
      bad++;
      $display("FAIL div_overflow: n=%0d hi=%h lo=%h want 10 0/80000000", n, md_if.hi, md_if.lo);
    end
    issue(3'd3, 32'd5, 32'd0);
    wait_idle(n);
    total++;
    if (n != 10) begin
      bad++;
      $display("FAIL divzero_busy: got %0d cycles want 10", n);
    end
    total++;
    if (md_if.hi !== 32'd0 || md_if.lo !== 32'h8000_0000) begin
      bad++;
      $display("FAIL divzero_keep: hi=%h lo=%h want 0/80000000", md_if.hi, md_if.lo);
    end
  endtask

  task automatic test_mthi_mtlo();
    int risen;
    risen = 0;
    md_if.start = 1'b1;
    md_if.op    = 3'd4;
    md_if.a     = 32'h1234;
    step();
    if (md_if.busy !== 1'b0) risen++;
    total++;
    if (md_if.hi !== 32'h1234 || md_if.lo !== 32'h8000_0000) begin
      bad++;
      $display("FAIL mthi: hi=%h lo=%h want 00001234/80000000", md_if.hi, md_if.lo);
    end
    md_if.op = 3'd5;
    md_if.a  = 32'h5678;
    step();
    md_if.start = 1'b0;
    if (md_if.busy !== 1'b0) risen++;
    step();
    if (md_if.busy !== 1'b0) risen++;
    total++;
    if (md_if.hi !== 32'h1234 || md_if.lo !== 32'h5678 || risen != 0) begin
      bad++;
      $display("FAIL mtlo: hi=%h lo=%h busy_hits=%0d want 00001234/00005678/0",
               md_if.hi, md_if.lo, risen);
    end
    // Op 6 with start must leave everything alone.
    issue(3'd6, 32'hDEAD_BEEF, 32'd1);
    total++;
    if (md_if.busy !== 1'b0 || md_if.hi !== 32'h1234 || md_if.lo !== 32'h5678) begin
      bad++;
      $display("FAIL noop: busy=%b hi=%h lo=%h want 0/00001234/00005678",
               md_if.busy, md_if.hi, md_if.lo);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    issue(3'd2, 32'd100, 32'd7);
    step(); step();
    issue(3'd0, 32'd3, 32'd4);  // ignored: DIV in flight
    wait_idle(n);
    total++;
    if (n != 7) begin
      bad++;
      $display("FAIL ignore_busy_len: remaining %0d cycles want 7", n);
    end
    total++;
    if (md_if.hi !== 32'd2 || md_if.lo !== 32'd14) begin
      bad++;
      $display("FAIL ignore_result: hi=%h lo=%h want 2/14", md_if.hi, md_if.lo);
    end
    issue(3'd1, 32'd3, 32'd4);
    total++;
    if (md_if.busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_accept: busy=%b want 1", md_if.busy);
    end
    wait_idle(n);
    total++;
    if (n != 5 || md_if.hi !== 32'd0 || md_if.lo !== 32'd12) begin
      bad++;
      $display("FAIL b2b_result: n=%0d hi=%h lo=%h want 5 0/12", n, md_if.hi, md_if.lo);
    end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst         = 1'b0;
    md_if.start = 1'b0;
    md_if.op    = 3'd7;
    md_if.a     = 32'd0;
    md_if.b     = 32'd0;
    test_reset();
    test_mult();
    test_div();
    test_div_edges();
    test_mthi_mtlo();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
